// File: rtl/lsh_pkg.sv
// Shared defaults, FSM state type and sizing helper for the LSH bucket table.
`timescale 1ns/1ps
package lsh_pkg;
  localparam int DEF_SKETCH_SIZE         = 16;
  localparam int DEF_NUM_OF_BUCKETS      = 256;
  localparam int DEF_LOG2_NUM_OF_BUCKETS = 8;
  localparam int DEF_BUCKET_SIZE         = 16;
  localparam int DEF_WINDOW_ID_W         = 10;
  localparam int DEF_COUNT_W             = 8;
  localparam int OVF_W                   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSERT = 2'd1,
    ST_QUERY  = 2'd2,
    ST_DONE   = 2'd3
  } lsh_state_e;

  // A bucket length must be able to hold the value BUCKET_SIZE itself.
  function automatic int len_width(input int bucket_size);
    return $clog2(bucket_size + 1);
  endfunction
endpackage

// File: rtl/lsh_count_mem.sv
// Per-window hit counters with touched flags, saturating increment and a registered read port.
`timescale 1ns/1ps
module lsh_count_mem
  import lsh_pkg::*;
#(
  parameter int WINDOW_ID_W = DEF_WINDOW_ID_W,
  parameter int COUNT_W     = DEF_COUNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr_touched,
  input  logic                   i_upd_en,
  input  logic [WINDOW_ID_W-1:0] i_upd_id,
  output logic [COUNT_W-1:0]     o_upd_count,
  input  logic [WINDOW_ID_W-1:0] i_rd_addr,
  output logic [COUNT_W-1:0]     o_rd_data
);
  localparam int MAX_WINDOWS = 2 ** WINDOW_ID_W;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [COUNT_W-1:0]     r_cnt [MAX_WINDOWS];
  logic [MAX_WINDOWS-1:0] r_touched;
  logic [COUNT_W-1:0]     r_rd_data;
  logic [COUNT_W-1:0]     w_old;

  // Untouched counters read as zero, so the array itself needs no clearing.
  assign w_old       = r_touched[i_upd_id] ? r_cnt[i_upd_id] : '0;
  assign o_upd_count = (w_old == CNT_MAX) ? CNT_MAX : w_old + 1'b1;
  assign o_rd_data   = r_rd_data;

  always_ff @(posedge clk) begin
    if (i_upd_en) r_cnt[i_upd_id] <= o_upd_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_touched <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_clr_touched)  r_touched <= '0;
      else if (i_upd_en)  r_touched[i_upd_id] <= 1'b1;
      r_rd_data <= r_touched[i_rd_addr] ? r_cnt[i_rd_addr] : '0;
    end
  end
endmodule

// File: rtl/lsh_bucket_table.sv
// LSH bucket table: sequential insert/query over hashed sketches with argmax result.
// Optional LSH_DEDUP_EN: skip an insert whose id equals the bucket's most recent entry.
`timescale 1ns/1ps
module lsh_bucket_table
  import lsh_pkg::*;
#(
  parameter int SKETCH_SIZE         = DEF_SKETCH_SIZE,
  parameter int NUM_OF_BUCKETS      = DEF_NUM_OF_BUCKETS,
  parameter int LOG2_NUM_OF_BUCKETS = DEF_LOG2_NUM_OF_BUCKETS,
  parameter int BUCKET_SIZE         = DEF_BUCKET_SIZE,
  parameter int WINDOW_ID_W         = DEF_WINDOW_ID_W,
  parameter int COUNT_W             = DEF_COUNT_W
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic                                       cmd_is_query,
  input  logic [WINDOW_ID_W-1:0]                     window_id,
  input  logic [SKETCH_SIZE*LOG2_NUM_OF_BUCKETS-1:0] hashed_sketch,
  input  logic                                       clr,
  output logic                                       done,
  output logic [WINDOW_ID_W-1:0]                     best_id,
  output logic [COUNT_W-1:0]                         best_count,
  output logic [OVF_W-1:0]                           overflow_cnt,
  input  logic [WINDOW_ID_W-1:0]                     cnt_rd_addr,
  output logic [COUNT_W-1:0]                         cnt_rd_data,
  output logic [1:0]                                 o_dbg_state
);
  localparam int LEN_W  = len_width(BUCKET_SIZE);
  localparam int SLOT_W = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;
  localparam int S_W    = (SKETCH_SIZE > 1) ? $clog2(SKETCH_SIZE) : 1;
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_INSERT = ST_INSERT;
  localparam logic [1:0] S_QUERY  = ST_QUERY;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]                                 r_state;
  logic [WINDOW_ID_W-1:0]                     r_id;
  logic [SKETCH_SIZE*LOG2_NUM_OF_BUCKETS-1:0] r_sketch;
  logic [S_W-1:0]                             r_s;
  logic [SLOT_W-1:0]                          r_e;
  logic [LEN_W-1:0]                           r_len   [NUM_OF_BUCKETS];
  logic [WINDOW_ID_W-1:0]                     r_table [NUM_OF_BUCKETS][BUCKET_SIZE];
  logic [WINDOW_ID_W-1:0]                     r_best_id;
  logic [COUNT_W-1:0]                         r_best_count;
  logic [OVF_W-1:0]                           r_ovf;

  logic [LOG2_NUM_OF_BUCKETS-1:0] w_b;
  logic [LEN_W-1:0]               w_len_b;
  logic [SLOT_W-1:0]              w_slot;
  logic [WINDOW_ID_W-1:0]         w_q_id;
  logic [COUNT_W-1:0]             w_new_cnt;
  logic w_accept, w_full, w_dup, w_ins_wr, w_s_last, w_q_last_e, w_upd_en, w_better;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE with clr low, and inputs are latched on that edge.
  assign cmd_ready    = (r_state == S_IDLE) && !clr;
  assign w_accept     = cmd_valid && cmd_ready;
  assign done         = (r_state == S_DONE);
  assign best_id      = r_best_id;
  assign best_count   = r_best_count;
  assign overflow_cnt = r_ovf;
  assign o_dbg_state  = r_state;

  assign w_b      = r_sketch[r_s*LOG2_NUM_OF_BUCKETS +: LOG2_NUM_OF_BUCKETS];
  assign w_len_b  = r_len[w_b];
  assign w_slot   = w_len_b[SLOT_W-1:0];
  assign w_full   = (w_len_b >= LEN_W'(BUCKET_SIZE));
  assign w_s_last = (r_s == S_W'(SKETCH_SIZE - 1));

`ifdef LSH_DEDUP_EN
  logic [SLOT_W-1:0] w_last_slot;
  assign w_last_slot = SLOT_W'(w_len_b - 1'b1);
  assign w_dup       = (w_len_b != '0) && (r_table[w_b][w_last_slot] == r_id);
`else
  assign w_dup = 1'b0;
`endif

  assign w_ins_wr   = (r_state == S_INSERT) && !w_full && !w_dup;
  assign w_q_id     = r_table[w_b][r_e];
  assign w_upd_en   = (r_state == S_QUERY) && (w_len_b != '0);
  // An empty bucket still spends one cycle, so it counts as its own last entry.
  assign w_q_last_e = (w_len_b == '0) || (LEN_W'(r_e) == w_len_b - 1'b1);
  assign w_better   = (w_new_cnt > r_best_count) ||
                      ((w_new_cnt == r_best_count) && (w_q_id < r_best_id));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_id         <= '0;
      r_sketch     <= '0;
      r_s          <= '0;
      r_e          <= '0;
      r_best_id    <= '0;
      r_best_count <= '0;
      r_ovf        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id     <= window_id;
            r_sketch <= hashed_sketch;
            r_s      <= '0;
            r_e      <= '0;
            if (cmd_is_query) begin
              r_state      <= S_QUERY;
              r_best_id    <= '0;
              r_best_count <= '0;
            end else begin
              r_state <= S_INSERT;
            end
          end
        end
        S_INSERT: begin
          if (w_full && !w_dup && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
          if (w_s_last) r_state <= S_DONE;
          else          r_s     <= r_s + 1'b1;
        end
        S_QUERY: begin
          if (w_upd_en && w_better) begin
            r_best_id    <= w_q_id;
            r_best_count <= w_new_cnt;
          end
          if (w_q_last_e) begin
            r_e <= '0;
            if (w_s_last) r_state <= S_DONE;
            else          r_s     <= r_s + 1'b1;
          end else begin
            r_e <= r_e + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bucket lengths alone define occupancy; reset and clr never touch the entry storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OF_BUCKETS; i++) r_len[i] <= '0;
    end else if ((r_state == S_IDLE) && clr) begin
      for (int i = 0; i < NUM_OF_BUCKETS; i++) r_len[i] <= '0;
    end else if (w_ins_wr) begin
      r_len[w_b] <= w_len_b + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ins_wr) r_table[w_b][w_slot] <= r_id;
  end

  lsh_count_mem #(
    .WINDOW_ID_W (WINDOW_ID_W),
    .COUNT_W     (COUNT_W)
  ) u_count_mem (
    .clk           (clk),
    .rst_n         (reset),
    .i_clr_touched (w_accept && cmd_is_query),
    .i_upd_en      (w_upd_en),
    .i_upd_id      (w_q_id),
    .o_upd_count   (w_new_cnt),
    .i_rd_addr     (cnt_rd_addr),
    .o_rd_data     (cnt_rd_data)
  );
endmodule

// File: tb/tb_lsh_bucket_table.sv
// Bench for lsh_bucket_table: directed vector table, abort-on-reset sequence, random run vs model.
`timescale 1ns/1ps
module tb_lsh_bucket_table;
  localparam int SS = 16, NB = 256, LB = 8, BS = 16, IW = 10, CW = 8;
  localparam int MAXW = 1024, CMAX = 255, OMAX = 65535, BUDGET = 2000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_is_query = 1'b0;
  logic [IW-1:0]     window_id = '0;
  logic [SS*LB-1:0]  hashed_sketch = '0;
  logic              clr = 1'b0;
  logic              done;
  logic [IW-1:0]     best_id;
  logic [CW-1:0]     best_count;
  logic [15:0]       overflow_cnt;
  logic [IW-1:0]     cnt_rd_addr = '0;
  logic [CW-1:0]     cnt_rd_data;
  logic [1:0]        o_dbg_state;

  lsh_bucket_table dut (
    .clk (clk), .reset (reset), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_is_query (cmd_is_query), .window_id (window_id), .hashed_sketch (hashed_sketch),
    .clr (clr), .done (done), .best_id (best_id), .best_count (best_count),
    .overflow_cnt (overflow_cnt), .cnt_rd_addr (cnt_rd_addr), .cnt_rd_data (cnt_rd_data),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  int sk[SS];
  int m_len[NB];
  int m_tab[NB][BS];
  int m_cnt[MAXW];
  int m_ovf, m_best_id, m_best_cnt, m_lat;

  function automatic void m_clear();
    for (int b = 0; b < NB; b++) m_len[b] = 0;
  endfunction

  function automatic void m_reset();
    m_clear();
    for (int w = 0; w < MAXW; w++) m_cnt[w] = 0;
    m_ovf = 0; m_best_id = 0; m_best_cnt = 0;
  endfunction

  function automatic void m_insert(input int id);
    int b;
    bit dup;
    for (int s = 0; s < SS; s++) begin
      b = sk[s];
`ifdef LSH_DEDUP_EN
      dup = (m_len[b] > 0) && (m_tab[b][m_len[b]-1] == id);
`else
      dup = 1'b0;
`endif
      if (!dup) begin
        if (m_len[b] < BS) begin
          m_tab[b][m_len[b]] = id;
          m_len[b]++;
        end else if (m_ovf < OMAX) begin
          m_ovf++;
        end
      end
    end
    m_lat = SS + 1;
  endfunction

  function automatic void m_query();
    int b, id, c;
    for (int w = 0; w < MAXW; w++) m_cnt[w] = 0;
    m_best_id = 0; m_best_cnt = 0; m_lat = 1;
    for (int s = 0; s < SS; s++) begin
      b = sk[s];
      m_lat += (m_len[b] > 0) ? m_len[b] : 1;
      for (int e = 0; e < m_len[b]; e++) begin
        id = m_tab[b][e];
        c = (m_cnt[id] + 1 > CMAX) ? CMAX : m_cnt[id] + 1;
        m_cnt[id] = c;
        if (c > m_best_cnt || (c == m_best_cnt && id < m_best_id)) begin
          m_best_cnt = c;
          m_best_id  = id;
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [SS*LB-1:0] pack_sketch();
    logic [SS*LB-1:0] v;
    v = '0;
    for (int s = 0; s < SS; s++) v[s*LB +: LB] = LB'(sk[s]);
    return v;
  endfunction

  function automatic void set_pattern(input int pat);
    for (int s = 0; s < SS; s++) sk[s] = (pat == 0) ? 0 : (pat == 1) ? s : 7;
  endfunction

  task automatic run_cmd(input bit q, input int id, output int lat);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_is_query = q; window_id = IW'(id); hashed_sketch = pack_sketch();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", BUDGET);
    end
    @(posedge clk); #1;
    chk("done_single_cycle", 32'(done), 0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    #1 chk("ready_low_during_clr", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic rd_one(input int addr);
    exp_q.push_back(32'(m_cnt[addr]));
    @(negedge clk);
    cnt_rd_addr = IW'(addr);
    @(posedge clk); #1;
    chk($sformatf("cnt_rd_data[%0d]", addr), 32'(cnt_rd_data), exp_q.pop_front());
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit clr_first;
    bit is_query;
    int id;
    int pat;       // 0: all zero, 1: ramp 0..15, 2: all 7
    int exp_lat;
    int exp_bid;
    int exp_bcnt;
    int exp_ovf;
  } vec_t;
  vec_t vt[9];

  initial begin
    int lat;
    bit saw_done;

`ifdef LSH_DEDUP_EN
    vt[0] = '{0, 0, 14, 0,  17,  0,   0, 0};
    vt[1] = '{0, 1,  0, 0,  17, 14,  16, 0};
    vt[2] = '{1, 0,  3, 1,  17, 14,  16, 0};
    vt[3] = '{0, 0,  5, 1,  17, 14,  16, 0};
    vt[4] = '{0, 1,  0, 1,  33,  3,  16, 0};
    vt[5] = '{0, 0,  9, 2,  17,  3,  16, 0};
    vt[6] = '{0, 0, 11, 1,  17,  3,  16, 0};
    vt[7] = '{0, 1,  0, 2,  65,  3,  16, 0};
    vt[8] = '{1, 1,  0, 1,  17,  0,   0, 0};
`else
    vt[0] = '{0, 0, 14, 0,  17,  0,   0, 0};
    vt[1] = '{0, 1,  0, 0, 257, 14, 255, 0};
    vt[2] = '{1, 0,  3, 1,  17, 14, 255, 0};
    vt[3] = '{0, 0,  5, 1,  17, 14, 255, 0};
    vt[4] = '{0, 1,  0, 1,  33,  3,  16, 0};
    vt[5] = '{0, 0,  9, 2,  17,  3,  16, 2};
    vt[6] = '{0, 0, 11, 1,  17,  3,  16, 3};
    vt[7] = '{0, 1,  0, 2, 257,  9, 224, 3};
    vt[8] = '{1, 1,  0, 1,  17,  0,   0, 3};
`endif

    // reset state
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_best_id", 32'(best_id), 0);
    chk("rst_best_count", 32'(best_count), 0);
    chk("rst_overflow", 32'(overflow_cnt), 0);
    chk("rst_state", 32'(o_dbg_state), 0);
    rd_one(0);
    rd_one(14);

    // directed table
    for (int i = 0; i < 9; i++) begin
      if (vt[i].clr_first) begin do_clr(); m_clear(); end
      set_pattern(vt[i].pat);
      run_cmd(vt[i].is_query, vt[i].id, lat);
      if (vt[i].is_query) m_query(); else m_insert(vt[i].id);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_best_id", i), 32'(best_id), 32'(vt[i].exp_bid));
      chk($sformatf("vec%0d_best_count", i), 32'(best_count), 32'(vt[i].exp_bcnt));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow_cnt), 32'(vt[i].exp_ovf));
      if (vt[i].is_query) begin
        rd_one(vt[i].exp_bid);
        rd_one(0);
        rd_one(5);
        rd_one(9);
      end
    end

    // random commands against the model
    do_clr(); m_clear();
    for (int n = 0; n < 40; n++) begin
      bit q;
      int id, a;
      if ($urandom_range(0, 7) == 0) begin do_clr(); m_clear(); end
      q  = ($urandom_range(0, 2) == 0);
      id = $urandom_range(0, 31);
      for (int s = 0; s < SS; s++) sk[s] = $urandom_range(0, 9);
      run_cmd(q, id, lat);
      if (q) m_query(); else m_insert(id);
      chk("rnd_latency", 32'(lat), 32'(m_lat));
      chk("rnd_best_id", 32'(best_id), 32'(m_best_id));
      chk("rnd_best_count", 32'(best_count), 32'(m_best_cnt));
      chk("rnd_overflow", 32'(overflow_cnt), 32'(m_ovf));
      if (q) begin
        a = (m_len[sk[0]] > 0) ? m_tab[sk[0]][0] : 0;
        rd_one(m_best_id);
        rd_one(a);
        rd_one($urandom_range(0, 31));
      end
    end

    // fill bucket 0, start a long query, then abort it with reset
    do_clr(); m_clear();
    set_pattern(0);
    run_cmd(1'b0, 1, lat);
    m_insert(1);
    chk("pre_abort_overflow", 32'(overflow_cnt), 32'(m_ovf));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_is_query = 1'b1; window_id = '0; hashed_sketch = pack_sketch();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("mid_query_state", 32'(o_dbg_state), 2);
    #2 reset = 1'b0;
    #1 chk("abort_done_in_reset", 32'(done), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    m_reset();
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    chk("abort_overflow", 32'(overflow_cnt), 0);
    chk("abort_best_count", 32'(best_count), 0);
    rd_one(1);
    run_cmd(1'b1, 0, lat);
    m_query();
    chk("post_abort_latency", 32'(lat), 32'(m_lat));
    chk("post_abort_best_count", 32'(best_count), 32'(m_best_cnt));
    chk("post_abort_best_id", 32'(best_id), 32'(m_best_id));
    rd_one(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
